// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: bundles the user-side push/pop signals and the RAM-side
// dual-port signals of the FIFO controller.
//   master - the FIFO controller (initiator on the RAM port)
//   slave  - the surrounding logic: user logic plus the dual-port RAM
interface fifo_ctrl_if #(
    parameter int mem_depth = 32,
    parameter int size      = 8
);
    localparam int AW = $clog2(mem_depth);

    // User side
    logic            write;
    logic            read;
    logic [size-1:0] data_in;
    logic [size-1:0] data_out;
    logic            rd_valid;
    logic            full;
    logic            empty;
    logic [AW:0]     use_dw;
    logic            overflow;
    logic            underflow;

    // RAM side
    logic [size-1:0] ram_data_in;
    logic            ram_wren;
    logic            ram_rden;
    logic [AW-1:0]   ram_wraddress;
    logic [AW-1:0]   ram_rdaddress;
    logic [size-1:0] ram_data_out;

    modport master (
        input  write, read, data_in, ram_data_out,
        output data_out, rd_valid, full, empty, use_dw, overflow, underflow,
        output ram_data_in, ram_wren, ram_rden, ram_wraddress, ram_rdaddress
    );

    modport slave (
        output write, read, data_in, ram_data_out,
        input  data_out, rd_valid, full, empty, use_dw, overflow, underflow,
        input  ram_data_in, ram_wren, ram_rden, ram_wraddress, ram_rdaddress
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller driving an external dual-port RAM.
// Turns push/pop requests into RAM write/read strobes and addresses, and
// tracks pointers, occupancy and full/empty status. The RAM is the data
// path: write data passes straight to it, and its registered read data is
// returned to the user one cycle after an accepted pop, with rd_valid.
module fifo_ctrl #(
    parameter int mem_depth = 32,
    parameter int size      = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    fifo_ctrl_if.master bus
);
    localparam int AW = $clog2(mem_depth);

    localparam logic [AW:0] C_DEPTH    = (AW+1)'(mem_depth);
    localparam logic [AW:0] C_DEPTH_M1 = (AW+1)'(mem_depth - 1);
    localparam logic [AW:0] C_ONE      = (AW+1)'(1);

    // Encoding chosen so that full and empty are each a single state bit.
    typedef enum logic [1:0] {
        S_PARTIAL = 2'b00,
        S_EMPTY   = 2'b01,
        S_FULL    = 2'b10
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_use_dw;
    logic            r_rd_valid;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_full;
    logic            w_empty;
    logic            w_push_ok;
    logic            w_pop_ok;
    logic [AW:0]     w_push_inc;
    logic [AW:0]     w_pop_dec;

    // ------------------------------------------------------------------
    // Acceptance, from registered state only.
    // A push is accepted when full only if a pop frees a slot in the same
    // cycle; a pop is never accepted when empty, so there is no bypass of
    // fresh write data straight to the read side.
    // ------------------------------------------------------------------
    assign w_full     = r_state[1];
    assign w_empty    = r_state[0];
    assign w_push_ok  = bus.write & (~w_full | bus.read);
    assign w_pop_ok   = bus.read & ~w_empty;
    assign w_push_inc = {{AW{1'b0}}, w_push_ok};
    assign w_pop_dec  = {{AW{1'b0}}, w_pop_ok};

    // RAM strobes are gated by reset so nothing is written or read while
    // the controller is held in reset, even if requests are asserted.
    assign bus.ram_wren      = w_push_ok & reset_n;
    assign bus.ram_rden      = w_pop_ok & reset_n;
    assign bus.ram_wraddress = r_wr_ptr;
    assign bus.ram_rdaddress = r_rd_ptr;
    assign bus.ram_data_in   = bus.data_in;

    // User-side outputs
    assign bus.data_out  = bus.ram_data_out;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.use_dw    = r_use_dw;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

    // Read/write pointers advance on accepted operations and wrap silently.
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values, independent of block evaluation order.
    // NOTE: only control state is reset; the RAM contents are left as they
    // are and are simply stale after reset, since the pointers restart at 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy count; push and pop in the same cycle cancel out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_use_dw <= '0;
        end else begin
            r_use_dw <= r_use_dw + w_push_inc - w_pop_dec;
        end
    end

    // Full/empty state machine; full and empty are read directly from the
    // state bits, never from a pointer compare.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    // Only a push can be accepted here.
                    if (w_push_ok) r_state <= S_PARTIAL;
                end
                S_PARTIAL: begin
                    if (w_push_ok && !w_pop_ok && r_use_dw == C_DEPTH_M1)
                        r_state <= S_FULL;
                    else if (w_pop_ok && !w_push_ok && r_use_dw == C_ONE)
                        r_state <= S_EMPTY;
                end
                S_FULL: begin
                    // Push+pop keeps the FIFO full; pop alone frees a slot.
                    if (w_pop_ok && !w_push_ok) r_state <= S_PARTIAL;
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    // Status pulses: read-data valid follows an accepted pop by one cycle;
    // overflow/underflow flag a rejected request for one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid  <= w_pop_ok;
            r_overflow  <= bus.write & ~w_push_ok;
            r_underflow <= bus.read & ~w_pop_ok;
        end
    end

    // Count never exceeds the depth; kept for readability of the bound.
    logic w_unused_depth;
    assign w_unused_depth = ^C_DEPTH;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl with a behavioural RAM and a
// queue-based reference model checked every cycle, plus literal checks.
module tb_fifo_ctrl;
    localparam int DEPTH = 32;
    localparam int W     = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    fifo_ctrl_if #(.mem_depth(DEPTH), .size(W)) bus ();

    fifo_ctrl #(.mem_depth(DEPTH), .size(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // Dual-port RAM with registered read; read-before-write on a collision.
    logic [W-1:0] ram_mem [DEPTH];
    logic [W-1:0] ram_q;
    always @(posedge clock) begin
        if (bus.ram_rden) ram_q <= ram_mem[bus.ram_rdaddress];
        if (bus.ram_wren) ram_mem[bus.ram_wraddress] <= bus.ram_data_in;
    end
    assign bus.ram_data_out = ram_q;

    // Reference model
    logic [W-1:0] q[$];
    bit           exp_rd_valid;
    bit           exp_ovf;
    bit           exp_udf;
    logic [W-1:0] exp_data;
    int           exp_wr_ptr;
    int           exp_rd_ptr;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit cmp_en       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_rd_valid = 1'b0;
        exp_ovf      = 1'b0;
        exp_udf      = 1'b0;
        exp_wr_ptr   = 0;
        exp_rd_ptr   = 0;
    endtask

    task automatic model_step(input bit w, input bit r, input logic [W-1:0] d);
        bit push_ok;
        bit pop_ok;
        push_ok = w && (q.size() < DEPTH || r);
        pop_ok  = r && (q.size() > 0);
        exp_rd_valid = pop_ok;
        if (pop_ok) begin
            exp_data   = q.pop_front();
            exp_rd_ptr = (exp_rd_ptr + 1) % DEPTH;
        end
        if (push_ok) begin
            q.push_back(d);
            exp_wr_ptr = (exp_wr_ptr + 1) % DEPTH;
        end
        exp_ovf = w && !push_ok;
        exp_udf = r && !pop_ok;
    endtask

    // Drive one cycle of requests, step the model at the edge, return just
    // after the edge so registered outputs can be inspected.
    task automatic do_cycle(input bit w, input bit r, input logic [W-1:0] d);
        bus.write   = w;
        bus.read    = r;
        bus.data_in = d;
        @(posedge clock);
        model_step(w, r, d);
        #1;
    endtask

    // Cycle-by-cycle comparison against the model, away from the edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("use_dw",    32'(bus.use_dw),    32'(q.size()));
            check("full",      32'(bus.full),      32'(q.size() == DEPTH));
            check("empty",     32'(bus.empty),     32'(q.size() == 0));
            check("rd_valid",  32'(bus.rd_valid),  32'(exp_rd_valid));
            check("overflow",  32'(bus.overflow),  32'(exp_ovf));
            check("underflow", 32'(bus.underflow), 32'(exp_udf));
            check("ram_wren",  32'(bus.ram_wren),
                  32'(reset_n && bus.write && (q.size() < DEPTH || bus.read)));
            check("ram_rden",  32'(bus.ram_rden),
                  32'(reset_n && bus.read && q.size() > 0));
            check("ram_wraddress", 32'(bus.ram_wraddress), 32'(exp_wr_ptr));
            check("ram_rdaddress", 32'(bus.ram_rdaddress), 32'(exp_rd_ptr));
            check("ram_data_in",   32'(bus.ram_data_in),   32'(bus.data_in));
            if (exp_rd_valid) check("data_out", 32'(bus.data_out), 32'(exp_data));
        end
    end

    initial begin
        logic [W-1:0] wd;
        logic [W-1:0] rd_exp;

        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.data_in = '0;
        model_reset();

        // Power-on reset
        repeat (2) @(posedge clock);
        #1;
        check("rst_empty",     32'(bus.empty),     32'd1);
        check("rst_full",      32'(bus.full),      32'd0);
        check("rst_use_dw",    32'(bus.use_dw),    32'd0);
        check("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
        check("rst_overflow",  32'(bus.overflow),  32'd0);
        check("rst_underflow", 32'(bus.underflow), 32'd0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Fill 0x00..0x1F
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, W'(i));
        check("fill_full",   32'(bus.full),   32'd1);
        check("fill_use_dw", 32'(bus.use_dw), 32'd32);
        check("fill_empty",  32'(bus.empty),  32'd0);

        // Push while full
        do_cycle(1'b1, 1'b0, 8'hAA);
        check("ovf_pulse",  32'(bus.overflow), 32'd1);
        check("ovf_use_dw", 32'(bus.use_dw),   32'd32);
        check("ovf_wren",   32'(bus.ram_wren), 32'd0);
        do_cycle(1'b0, 1'b0, 8'h00);
        check("ovf_once",   32'(bus.overflow), 32'd0);

        // Drain: 0x00..0x1F in order, 0xAA never stored
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 1'b1, 8'h00);
            check("drain_valid", 32'(bus.rd_valid), 32'd1);
            check("drain_data",  32'(bus.data_out), 32'(i));
        end
        check("drain_empty",  32'(bus.empty),  32'd1);
        check("drain_use_dw", 32'(bus.use_dw), 32'd0);

        // Pop while empty
        do_cycle(1'b0, 1'b1, 8'h00);
        check("udf_pulse", 32'(bus.underflow), 32'd1);
        check("udf_valid", 32'(bus.rd_valid),  32'd0);
        do_cycle(1'b0, 1'b0, 8'h00);
        check("udf_once",  32'(bus.underflow), 32'd0);

        // Push+pop while empty: only the push is taken
        do_cycle(1'b1, 1'b1, 8'h77);
        check("se_use_dw", 32'(bus.use_dw),   32'd1);
        check("se_valid",  32'(bus.rd_valid), 32'd0);
        check("se_empty",  32'(bus.empty),    32'd0);
        do_cycle(1'b0, 1'b1, 8'h00);
        check("se_pop_valid", 32'(bus.rd_valid), 32'd1);
        check("se_pop_data",  32'(bus.data_out), 32'h77);
        check("se_pop_empty", 32'(bus.empty),    32'd1);

        // Push+pop while full: both taken, oldest word returned
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, W'(8'h80 + i));
        do_cycle(1'b1, 1'b1, 8'h55);
        check("sf_use_dw", 32'(bus.use_dw),   32'd32);
        check("sf_full",   32'(bus.full),     32'd1);
        check("sf_valid",  32'(bus.rd_valid), 32'd1);
        check("sf_data",   32'(bus.data_out), 32'h80);
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 1'b1, 8'h00);
            rd_exp = (i == DEPTH - 1) ? 8'h55 : W'(8'h81 + i);
            check("sf_drain_data", 32'(bus.data_out), 32'(rd_exp));
        end
        check("sf_drain_empty", 32'(bus.empty), 32'd1);

        // Alternating push/pop across pointer wrap
        wd     = 8'hC0;
        rd_exp = 8'hC0;
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) begin
                do_cycle(1'b1, 1'b0, wd);
                wd = wd + 1'b1;
            end else begin
                do_cycle(1'b0, 1'b1, 8'h00);
                check("wrap_data", 32'(bus.data_out), 32'(rd_exp));
                rd_exp = rd_exp + 1'b1;
            end
            check("wrap_use_dw_le1", 32'(bus.use_dw <= 1), 32'd1);
        end

        // Reset mid-operation, asserted between edges
        do_cycle(1'b1, 1'b0, 8'h10);
        do_cycle(1'b1, 1'b0, 8'h11);
        do_cycle(1'b1, 1'b0, 8'h12);
        do_cycle(1'b1, 1'b1, 8'h13);
        check("pre_rst_valid",  32'(bus.rd_valid), 32'd1);
        check("pre_rst_data",   32'(bus.data_out), 32'h10);
        check("pre_rst_use_dw", 32'(bus.use_dw),   32'd3);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_empty",    32'(bus.empty),    32'd1);
        check("arst_full",     32'(bus.full),     32'd0);
        check("arst_use_dw",   32'(bus.use_dw),   32'd0);
        check("arst_wren",     32'(bus.ram_wren), 32'd0);
        check("arst_rden",     32'(bus.ram_rden), 32'd0);
        check("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
        @(posedge clock);
        #1;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        reset_n   = 1'b1;
        do_cycle(1'b1, 1'b0, 8'h3C);
        do_cycle(1'b0, 1'b1, 8'h00);
        check("post_rst_valid", 32'(bus.rd_valid), 32'd1);
        check("post_rst_data",  32'(bus.data_out), 32'h3C);
        do_cycle(1'b0, 1'b0, 8'h00);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous FIFO controller that acts as the initiator on the `ram_dp` dual-port RAM interface. It accepts push/pop requests from the user side and derives the RAM write enable, read enable and both addresses from them. It maintains the read and write pointers, the occupancy count and the full/empty status. The FIFO data path is the RAM itself: user write data passes straight through to the RAM, and RAM read data is returned to the user with a valid strobe.

## Interface

Parameters:
- `mem_depth`, default 32: number of FIFO entries; must equal the RAM depth and be a power of two, ≥ 4.
- `size`, default 8: data word width; must equal the RAM word width.
- AW = $clog2(mem_depth): pointer/address width, 5 by default. This is a derived constant, not a parameter.

Ports (clock and reset first):
- `clock` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `write` input 1: push request; `data_in` is written when the push is accepted.
- `read` input 1: pop request.
- `data_in` input size: push data.
- `data_out` output size: pop data, combinational pass-through of `ram_data_out`.
- `rd_valid` output 1: registered; high for one cycle when `data_out` holds the word of a pop accepted in the previous cycle.
- `full` output 1: registered; count == mem_depth.
- `empty` output 1: registered; count == 0.
- `use_dw` output AW+1: registered occupancy, 0..mem_depth.
- `overflow` output 1: registered one-cycle pulse after a rejected push.
- `underflow` output 1: registered one-cycle pulse after a rejected pop.
- `ram_data_in` output size: to RAM `data_in`, equal to `data_in`.
- `ram_wren` output 1: to RAM `wren`, combinational.
- `ram_rden` output 1: to RAM `rden`, combinational.
- `ram_wraddress` output AW: to RAM `wraddress`, equal to the write pointer.
- `ram_rdaddress` output AW: to RAM `rdaddress`, equal to the read pointer.
- `ram_data_out` input size: from RAM `data_out`.

## Operation

Acceptance, evaluated combinationally from the current registered state:
- `push_ok = write & (~full | read)`.
- `pop_ok = read & ~empty`.
- `ram_wren = push_ok`, `ram_rden = pop_ok`. Both are forced to 0 while `reset_n` = 0.

On each rising edge:
- If `push_ok`: wr_ptr ← wr_ptr + 1, modulo mem_depth (natural AW-bit wrap).
- If `pop_ok`: rd_ptr ← rd_ptr + 1, modulo mem_depth.
- `use_dw` ← `use_dw` + `push_ok` − `pop_ok`. Use AW+1-bit arithmetic; the result can never leave 0..mem_depth.

State machine, held in a 2-bit register; `full` and `empty` are decoded from it:
- EMPTY: push only → PARTIAL. Push+pop → PARTIAL, because the pop is rejected. Pop only → EMPTY with underflow.
- PARTIAL:
  - push only with `use_dw` = mem_depth−1 → FULL; otherwise stay PARTIAL.
  - pop only with `use_dw` = 1 → EMPTY; otherwise stay PARTIAL.
  - push+pop → PARTIAL.
- FULL: pop only → PARTIAL. Push+pop → FULL, with both accepted. Push only → FULL with overflow.

Boundary rules:
- Empty with push+pop: only the push is accepted; there is no bypass and no `rd_valid`.
- Full with push+pop: both are accepted, and the RAM returns the old word at rd_ptr.
- Pointer wrap from mem_depth−1 to 0 is silent; full and empty are distinguished by state/count, never by pointer compare.
- `overflow`/`underflow` are status only and leave all pointers unchanged.
- Reset mid-operation: all pointers and counts clear immediately; RAM contents are not cleared and are treated as stale.

## Timing

- Reset values: wr_ptr = 0, rd_ptr = 0, `use_dw` = 0, state = EMPTY, `empty` = 1, `full` = 0, `rd_valid` = 0, `overflow` = 0, `underflow` = 0.
- Push: data is written into the RAM at the edge where `push_ok` = 1. `use_dw`, `full` and `empty` reflect the push after that same edge.
- Pop latency is 1 cycle. For a pop accepted at edge N, the RAM registers the word at edge N, and `rd_valid` = 1 with `data_out` valid in the cycle after edge N.
- Write-to-read: a word pushed at edge N may be popped at edge N+1 at the earliest; it appears on `data_out` after edge N+1.
- Sustained throughput is one push and one pop per cycle.

## Test plan

- Reset: assert `reset_n` = 0 mid-run → `empty` = 1, `full` = 0, `use_dw` = 0, `ram_wren` = `ram_rden` = 0, `rd_valid` = 0, asynchronously without waiting for a clock edge.
- Fill/drain: push 0x00..0x1F → after the 32nd push `full` = 1 and `use_dw` = 32. Then pop 32 → `data_out` returns 0x00..0x1F in order, each with `rd_valid` = 1, and `empty` = 1 after the last pop.
- Overflow/underflow: push 0xAA when full → `overflow` pulses once, `use_dw` stays 32, the contents are unchanged. Pop when empty → `underflow` pulses once and `rd_valid` = 0.
- Simultaneous when full: push 0x55 and pop together → `use_dw` stays 32, `data_out` returns the oldest word, and 0x55 comes out 32 pops later.
- Simultaneous when empty: push 0x77 and pop together → `use_dw` = 1, `rd_valid` = 0. The next pop returns 0x77.
- Wrap-around: run 100 cycles of alternating push/pop with incrementing data → the pointers wrap past 31 → 0, the output sequence matches the input sequence, and `use_dw` stays at 0 or 1.
